// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   Converts a simple valid/ready command into one APB transfer
//   (IDLE -> SETUP -> ACCESS) and reports completion with a one-cycle
//   rsp_valid pulse. An ACCESS phase that sees pready low for TIMEOUT
//   consecutive edges is aborted and reported with rsp_err=1.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no transfer in flight; cmd_ready=1, waits for cmd_valid
//   SETUP  | psel=1, penable=0 for exactly one cycle
//   ACCESS | psel=1, penable=1; waits for pready or timeout
//
// Ports
//   pclk, presetn             clock, async active-low reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_write/addr/wdata      command fields, latched on accept
//   rsp_valid/rsp_err         completion pulse, err = timeout abort
//   rsp_rdata                 data of the last completed read
//   paddr..penable            APB requester outputs
//   prdata, pready            APB completer response
// -----------------------------------------------------------------------------
module apb_master #(
  parameter int DATA    = 32,
  parameter int ADDR    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [DATA-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [ADDR-1:0] paddr,
  output logic            pwrite,
  output logic [DATA-1:0] pwdata,
  output logic            psel,
  output logic            penable,
  input  logic [DATA-1:0] prdata,
  input  logic            pready
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Value the counter holds on the TIMEOUT-th consecutive pready-low edge;
  // the abort happens there, so the counter never climbs past it.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [ADDR-1:0] paddr_q;
  logic            pwrite_q;
  logic [DATA-1:0] pwdata_q;
  logic            psel_q;
  logic            penable_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [DATA-1:0] rsp_rdata_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // Response is a single-cycle pulse; err only ever qualifies valid.
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            paddr_q   <= cmd_addr;
            pwrite_q  <= cmd_write;
            pwdata_q  <= cmd_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (pready) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (!pwrite_q) begin
              rsp_rdata_q <= prdata;
            end
            state_q     <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign paddr     = paddr_q;
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DATA, default 32, data width of command, response and APB data buses.
REQ-002 Parameter ADDR, default 32, address width of command and APB address bus.
REQ-003 Parameter TIMEOUT, default 16, maximum ACCESS-phase edges with pready low before abort; legal range >= 1.
REQ-004 Port pclk, input, 1, single clock; all state changes on its rising edge.
REQ-005 Port presetn, input, 1, asynchronous active-low reset.
REQ-006 Port cmd_valid, input, 1, command request.
REQ-007 Port cmd_ready, output, 1, block can accept a command.
REQ-008 Port cmd_write, input, 1, 1 = write, 0 = read.
REQ-009 Port cmd_addr, input, ADDR, transfer address.
REQ-010 Port cmd_wdata, input, DATA, write data.
REQ-011 Port rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 Port rsp_rdata, output, DATA, read data of the last completed read.
REQ-013 Port rsp_err, output, 1, qualifies rsp_valid: 1 = timeout abort.
REQ-014 Ports paddr (output, ADDR), pwrite (output, 1), pwdata (output, DATA), psel (output, 1), penable (output, 1): APB requester signals.
REQ-015 Ports prdata (input, DATA) and pready (input, 1): APB completer response.

Function
REQ-016 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-017 cmd_ready SHALL equal 1 exactly when state is IDLE; it is decoded from state and is independent of cmd_valid.
REQ-018 IDLE, edge with cmd_valid=1: latch cmd_addr->paddr, cmd_write->pwrite, cmd_wdata->pwdata; psel<=1; penable<=0; go to SETUP.
REQ-019 IDLE, edge with cmd_valid=0: outputs hold; stay in IDLE.
REQ-020 SETUP SHALL last exactly one cycle: penable<=1; timeout counter<=0; go to ACCESS.
REQ-021 ACCESS, edge with pready=1: psel<=0; penable<=0; rsp_valid<=1; rsp_err<=0; if read, rsp_rdata<=prdata; go to IDLE.
REQ-022 A completed write SHALL leave rsp_rdata unchanged.
REQ-023 ACCESS, edge with pready=0: counter increments.
REQ-024 The TIMEOUT-th consecutive ACCESS edge with pready=0 SHALL abort: psel<=0, penable<=0, rsp_valid<=1, rsp_err<=1, rsp_rdata unchanged, go to IDLE.
REQ-025 pready and prdata SHALL be ignored outside ACCESS.
REQ-026 paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle, and SHALL hold their values after completion until the next accept.
REQ-027 rsp_valid SHALL be high for exactly one cycle per transfer, with no backpressure; rsp_err SHALL be 0 whenever rsp_valid is 0.
REQ-028 cmd_valid while not IDLE SHALL be ignored; no command is queued.
REQ-029 Minimum transfer: accept at edge N, SETUP cycle N..N+1, pready sampled at N+2, rsp_valid high in cycle N+2..N+3, next accept earliest at N+3.
REQ-030 The counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.

Reset
REQ-031 While presetn=0: state=IDLE; psel, penable, pwrite, rsp_valid and rsp_err are 0; paddr, pwdata, rsp_rdata and counter are 0; cmd_ready=1.
REQ-032 Reset asserted mid-transfer SHALL abort immediately and asynchronously, with no rsp_valid pulse.
REQ-033 After reset release, the first accept SHALL occur no earlier than the first edge with presetn=1.

Verification
REQ-034 Write 0xDEADBEEF to 0x10 into the team's APB memory completer (pready one cycle after psel&&penable): psel high 3 cycles, penable 2 cycles -> rsp_valid=1, rsp_err=0, memory[0x10]=0xDEADBEEF.
REQ-035 Read 0x10 after REQ-034 -> rsp_valid pulse with rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-036 cmd_valid held high for 4 writes (0x01..0x04 to 0x20..0x23) -> exactly 4 rsp_valid pulses, cmd_ready low during each transfer, memory matches.
REQ-037 pready tied 0, TIMEOUT=16, read 0x30 -> abort on the 16th ACCESS edge, rsp_valid=1, rsp_err=1, rsp_rdata unchanged, psel=0 next cycle.
REQ-038 presetn pulsed low during ACCESS -> psel=penable=0 at once, no rsp_valid, cmd_ready=1; a following read of 0x10 completes normally.
